// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: port A (display engine) has priority over port B; read data is routed back via an in-order tag FIFO.
// Optional anti-starvation guard for port B is enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int TAG_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_write,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rdata_en,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_write,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rdata_en,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rdata_en,
    output logic              tag_error
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] GRANT_A = 1'b0;
    localparam logic [0:0] GRANT_B = 1'b1;

    // Handshake: a requester holds valid/address/write/wdata until ready; a transfer
    // occurs on every cycle with valid & ready, on both the requester and VRAM sides.

    logic [0:0]       sel;
    logic             lock_q;
    logic [0:0]       lock_sel_q;
    logic             g_valid;
    logic             force_b;
    logic             tag_full;
    logic             tag_empty;
    logic             push;
    logic             pop;
    logic             xfer;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_cnt;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    logic [STV_W-1:0] starve_cnt;

    assign force_b = !lock_q && b_valid && (starve_cnt == STV_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!b_valid || (xfer && sel == GRANT_B)) begin
            starve_cnt <= '0;
        end else if (xfer && starve_cnt != STV_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Strict priority: B is never forced ahead of A.
    assign force_b = 1'b0 && (STARVE_LIMIT > 0);
`endif

    always_comb begin
        sel = GRANT_A;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (force_b) begin
            sel = GRANT_B;
        end else if (a_valid) begin
            sel = GRANT_A;
        end else if (b_valid) begin
            sel = GRANT_B;
        end
    end

    assign g_valid   = (sel == GRANT_B) ? b_valid   : a_valid;
    assign m_write   = (sel == GRANT_B) ? b_write   : a_write;
    assign m_address = (sel == GRANT_B) ? b_address : a_address;
    assign m_wdata   = (sel == GRANT_B) ? b_wdata   : a_wdata;

    assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);

    // Reads wait while every tag slot is in use; writes carry no tag and always pass.
    assign m_valid = g_valid && !(!m_write && tag_full);
    assign xfer    = m_valid && m_ready;
    assign a_ready = xfer && (sel == GRANT_A);
    assign b_ready = xfer && (sel == GRANT_B);

    assign push = xfer && !m_write;
    assign pop  = m_rdata_en && !tag_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            lock_sel_q <= GRANT_A;
        end else if (m_valid && !m_ready) begin
            lock_q     <= 1'b1;
            lock_sel_q <= sel;
        end else if (xfer || !g_valid) begin
            lock_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Return data goes to the owner of the oldest outstanding tag; an untagged return is flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata    <= '0;
            b_rdata    <= '0;
            a_rdata_en <= 1'b0;
            b_rdata_en <= 1'b0;
            tag_error  <= 1'b0;
        end else begin
            a_rdata_en <= 1'b0;
            b_rdata_en <= 1'b0;
            if (m_rdata_en) begin
                if (tag_empty) begin
                    tag_error <= 1'b1;
                end else if (tag_mem[rd_ptr] == GRANT_B) begin
                    b_rdata    <= m_rdata;
                    b_rdata_en <= 1'b1;
                end else begin
                    a_rdata    <= m_rdata;
                    a_rdata_en <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized two-port traffic against a VRAM model and an in-order return scoreboard.
module tb_vram_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] a_address, b_address, m_address;
    logic          a_write, b_write, m_write;
    logic          a_valid, b_valid, m_valid;
    logic          a_ready, b_ready, m_ready;
    logic [DW-1:0] a_wdata, b_wdata, m_wdata;
    logic [DW-1:0] a_rdata, b_rdata, m_rdata;
    logic          a_rdata_en, b_rdata_en, m_rdata_en;
    logic          tag_error;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_write(a_write), .a_valid(a_valid), .a_ready(a_ready),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
        .b_address(b_address), .b_write(b_write), .b_valid(b_valid), .b_ready(b_ready),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
        .m_address(m_address), .m_write(m_write), .m_valid(m_valid), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_rdata_en(m_rdata_en),
        .tag_error(tag_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected returns in issue order: {port (0=A,1=B), data}.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] vram    [0:(1<<AW)-1];
    logic [DW-1:0] pend[$];
    int            outst = 0;
    int            ready_mode = 0;
    bit            ret_en = 1'b1;
    int            ret_pct = 100;
    bit            inject = 1'b0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_write;
    logic [DW-1:0] prev_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input bit port, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        if (wr) ref_mem[addr] = d;
        else exp_q.push_back({port, ref_mem[addr]});
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: got no ready, expected ready within 300 cycles", name);
    endtask

    task automatic a_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        int n = 0;
        a_valid = 1'b1; a_write = wr; a_address = addr; a_wdata = d;
        @(negedge clk);
        while (!a_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (a_ready) accept(1'b0, wr, addr, d);
        else timeout_fail("a_timeout");
        step();
        a_valid = 1'b0;
    endtask

    task automatic b_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        int n = 0;
        b_valid = 1'b1; b_write = wr; b_address = addr; b_wdata = d;
        @(negedge clk);
        while (!b_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (b_ready) accept(1'b1, wr, addr, d);
        else timeout_fail("b_timeout");
        step();
        b_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // VRAM side: drives m_ready and in-order read returns just after each rising edge.
    initial begin
        m_ready = 1'b0; m_rdata = '0; m_rdata_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_rdata_en = 1'b0;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (inject) begin
                m_rdata = 8'hEE; m_rdata_en = 1'b1; inject = 1'b0;
            end else if (ret_en && pend.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
                m_rdata = pend.pop_front(); m_rdata_en = 1'b1;
            end
        end
    end

    // VRAM side observation: memory updates, request stability while waiting, tag-limit stall.
    always @(negedge clk) begin
        if (!reset_n) begin
            outst = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_addr", m_address, prev_addr);
                check("hold_write", m_write, prev_write);
                check("hold_wdata", m_wdata, prev_wdata);
            end
            if (m_valid && !m_write) check("read_limit", 32'(outst < TD), 1);
            if (m_valid && m_ready) begin
                if (m_write) vram[m_address] = m_wdata;
                else begin
                    pend.push_back(vram[m_address]);
                    outst++;
                end
            end
            if (m_rdata_en && outst > 0) outst--;
            prev_stall = m_valid && !m_ready;
            prev_addr = m_address; prev_write = m_write; prev_wdata = m_wdata;
        end
    end

    task automatic ret_check(input bit port, input logic [DW-1:0] data);
        logic [DW:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL ret_unexpected: got port %0d data 0x%0h, expected no return", port, data);
        end else begin
            e = exp_q.pop_front();
            check("ret_port", 32'(port), 32'(e[DW]));
            check("ret_data", data, e[DW-1:0]);
        end
    endtask

    always @(negedge clk) begin
        if (a_rdata_en) ret_check(1'b0, a_rdata);
        if (b_rdata_en) ret_check(1'b1, b_rdata);
    end

    // Holds one port waiting on a VRAM that refuses, then brings the other port in.
    task automatic lock_test(input bit b_first);
        logic [AW-1:0] fa;
        fa = b_first ? 14'h0200 : 14'h0100;
        @(negedge clk);
        ready_mode = 1;
        step();
        fork
            if (b_first) b_xfer(1'b1, 14'h0200, 8'h77); else a_xfer(1'b0, 14'h0100, 8'h00);
            begin
                step();
                if (b_first) a_xfer(1'b0, 14'h0100, 8'h00); else b_xfer(1'b1, 14'h0200, 8'h77);
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("lock_addr", m_address, fa);
                    check("lock_ready", {a_ready, b_ready}, 0);
                end
                ready_mode = 0;
            end
        join
    endtask

    initial begin
        int n_a;
        int first_b;
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_a;
        int first_b;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i] = '0;
            ref_mem[i] = '0;
        end
        a_valid = 0; a_write = 0; a_address = '0; a_wdata = '0;
        b_valid = 0; b_write = 0; b_address = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle after reset
        @(negedge clk);
        check("t1_m_valid", m_valid, 0);
        check("t1_rdata_en", {a_rdata_en, b_rdata_en}, 0);
        check("t1_tag_error", tag_error, 0);
        step();

        // Simultaneous A write and B read
        vram[14'h0040] = 8'hC3; ref_mem[14'h0040] = 8'hC3;
        fork
            a_xfer(1'b1, 14'h0123, 8'h5A);
            b_xfer(1'b0, 14'h0040, 8'h00);
            begin
                @(negedge clk);
                check("t2_a_first", {a_ready, b_ready}, 2'b10);
                check("t2_addr_a", m_address, 14'h0123);
                @(negedge clk);
                check("t2_b_next", {a_ready, b_ready}, 2'b01);
                check("t2_addr_b", m_address, 14'h0040);
            end
        join
        wait_drain();
        check("t2_vram_write", vram[14'h0123], 8'h5A);

        // Grant held while VRAM is not ready
        lock_test(1'b0);
        wait_drain();
        lock_test(1'b1);
        wait_drain();

        // Tag FIFO full stalls the fifth read until the first return
        ret_en = 1'b0;
        vram[14'h0010] = 8'h11; vram[14'h0011] = 8'h22; vram[14'h0012] = 8'h33;
        vram[14'h0013] = 8'h44; vram[14'h0014] = 8'h55;
        ref_mem[14'h0010] = 8'h11; ref_mem[14'h0011] = 8'h22; ref_mem[14'h0012] = 8'h33;
        ref_mem[14'h0013] = 8'h44; ref_mem[14'h0014] = 8'h55;
        a_xfer(1'b0, 14'h0010, 8'h00);
        b_xfer(1'b0, 14'h0011, 8'h00);
        a_xfer(1'b0, 14'h0012, 8'h00);
        b_xfer(1'b0, 14'h0013, 8'h00);
        fork
            a_xfer(1'b0, 14'h0014, 8'h00);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t4_stall", m_valid, 0);
                end
                ret_en = 1'b1;
                @(negedge clk);
                check("t4_hold", a_ready, 0);
                @(negedge clk);
                check("t4_release", a_ready, 1);
            end
        join
        wait_drain();

        // Both ports streaming writes: B's first grant depends on the starvation guard
        n_a = 0;
        first_b = -1;
        a_valid = 1; a_write = 1; a_address = 14'h3001; a_wdata = 8'hAA;
        b_valid = 1; b_write = 1; b_address = 14'h3002; b_wdata = 8'hBB;
        for (int i = 0; i < 30 && first_b < 0; i++) begin
            @(negedge clk);
            if (a_ready) begin
                n_a++;
                ref_mem[14'h3001] = 8'hAA;
            end
            if (b_ready) begin
                first_b = n_a;
                ref_mem[14'h3002] = 8'hBB;
            end
        end
        step();
        a_valid = 0; b_valid = 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        check("t6_b_after_8", first_b, 8);
`else
        check("t6_b_starved", first_b, 32'hFFFF_FFFF);
`endif
        check("t6_a_count", n_a, (first_b < 0) ? 30 : 8);

        // Randomized two-port traffic with random VRAM readiness and return latency
        ready_mode = 2;
        ret_pct = 50;
        fork
            for (int i = 0; i < 120; i++) begin
                repeat ($urandom_range(0, 2)) step();
                a_xfer(1'($urandom_range(0, 1)), 14'($urandom_range(0, 31)), 8'($urandom));
            end
            for (int i = 0; i < 120; i++) begin
                repeat ($urandom_range(0, 2)) step();
                b_xfer(1'($urandom_range(0, 1)), 14'($urandom_range(0, 31)), 8'($urandom));
            end
        join
        ready_mode = 0;
        ret_pct = 100;
        wait_drain();
        check("rand_tag_error", tag_error, 0);

        // Return with no outstanding read
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_tag_error", tag_error, 1);
        check("t5_no_rdata_en", {a_rdata_en, b_rdata_en}, 0);
        @(negedge clk);
        check("t5_sticky", tag_error, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_reset_clear", tag_error, 0);
        check("t5_reset_m_valid", m_valid, 0);
        pend.delete();
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_after_reset", tag_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
